major_state_seq: RTL

- Central major-state sequencer for the PDP-8e core. It drives the 4-bit `state` bus consumed by `ma`, `pc` and the other datapath blocks.
- It steps each instruction through Fetch (F0-F3), optional Defer (D0-D3) and optional Execute (E0-E3), and parks in Halt (H0-H3) when required.
- It also converts front-panel switch requests (load address, deposit, examine, continue) into one-H-cycle strobes aligned to H1-H2.

---
 rtl/major_state_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/major_state_seq.sv
// major_state_seq: major-state sequencer for the PDP-8e core.
// Steps each instruction through Fetch (F0-F3), optional Defer (D0-D3) and
// optional Execute (E0-E3). It parks in Halt (H0-H3) when the machine must
// stop. While halted it turns front-panel requests into strobes that span
// H1-H2.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   instruction current instruction word from ma, bit 0 = MSB (valid from F1)
//   halt_sw     front-panel HALT level
//   sing_step   front-panel SINGLE STEP level
//   cont_sw     CONTINUE request pulse
//   loadd_sw    LOAD ADDRESS request pulse
//   depd_sw     DEPOSIT request pulse
//   examd_sw    EXAMINE request pulse
//   state       major state code (F0=0 .. H3=15)
//   run         high outside H0-H3
//   addr_loadd  load-address strobe (H1-H2)
//   depd        deposit strobe (H1-H2)
//   examd       examine strobe (H1-H2)
//   instr_done  high on the final state of each completed instruction
module major_state_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] instruction,
  input  logic        halt_sw,
  input  logic        sing_step,
  input  logic        cont_sw,
  input  logic        loadd_sw,
  input  logic        depd_sw,
  input  logic        examd_sw,
  output logic [3:0]  state,
  output logic        run,
  output logic        addr_loadd,
  output logic        depd,
  output logic        examd,
  output logic        instr_done
);

  localparam logic [3:0] F0 = 4'd0,  F1 = 4'd1,  F2 = 4'd2,  F3 = 4'd3;
  localparam logic [3:0] D0 = 4'd4,  D1 = 4'd5,  D2 = 4'd6,  D3 = 4'd7;
  localparam logic [3:0] E0 = 4'd8,  E1 = 4'd9,  E2 = 4'd10, E3 = 4'd11;
  localparam logic [3:0] H0 = 4'd12, H1 = 4'd13, H2 = 4'd14, H3 = 4'd15;

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_LOADD = 2'd1;
  localparam logic [1:0] SEL_DEPD  = 2'd2;
  localparam logic [1:0] SEL_EXAMD = 2'd3;

  logic [3:0] state_next;
  logic [2:0] ir_op;       // opcode captured in F3, used by the D3 decision
  logic [2:0] pend;        // {loadd, depd, examd} pending panel requests
  logic [2:0] pend_clr;
  logic [1:0] pick;
  logic [1:0] sel;         // request being serviced in the current H cycle
  logic       pend_cont;
  logic       halted;
  logic       halt_req;
  logic       cont_eval;
  logic [2:0] cur_op;
  logic       cur_i;
  logic       is_hlt;
  logic       to_defer;
  logic       to_exec;

  assign cur_op   = instruction[0:2];
  assign cur_i    = instruction[3];
  // Group-2 operate HLT: opcode 7 with bit 3 (group 2) and bit 10 (HLT) set.
  assign is_hlt   = (cur_op == 3'd7) && instruction[3] && instruction[10];
  assign to_defer = (cur_op <= 3'd5) && cur_i;
  assign to_exec  = (cur_op <= 3'd4);
  assign halted   = state[3] & state[2];
  assign halt_req = halt_sw | sing_step;
  // A continue is only considered once the H cycle carried no panel
  // operation and nothing else is queued behind it.
  assign cont_eval = (state == H3) && pend_cont && (sel == SEL_NONE) && (pend == 3'b000);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= H0;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state + 4'd1;
    case (state)
      F3: begin
        if (to_defer)                 state_next = D0;
        else if (to_exec)             state_next = E0;
        else if (is_hlt || halt_req)  state_next = H0;
        else                          state_next = F0;
      end
      D3: begin
        if (ir_op <= 3'd4)            state_next = E0;
        else                          state_next = halt_req ? H0 : F0;
      end
      E3:                             state_next = halt_req ? H0 : F0;
      H3:                             state_next = (cont_eval && !halt_sw) ? F0 : H0;
      default:                        state_next = state + 4'd1;
    endcase
  end

  // Output logic
  always_comb begin
    run        = ~halted;
    instr_done = 1'b0;
    if (state == F3 && !to_defer && !to_exec) instr_done = 1'b1;
    if (state == D3 && ir_op > 3'd4)          instr_done = 1'b1;
    if (state == E3)                          instr_done = 1'b1;
    addr_loadd = (sel == SEL_LOADD) && (state == H1 || state == H2);
    depd       = (sel == SEL_DEPD)  && (state == H1 || state == H2);
    examd      = (sel == SEL_EXAMD) && (state == H1 || state == H2);
  end

  // Priority pick of the pending panel request, taken at H0
  always_comb begin
    pick     = SEL_NONE;
    pend_clr = 3'b000;
    if (state == H0) begin
      if (pend[2])      begin pick = SEL_LOADD; pend_clr = 3'b100; end
      else if (pend[1]) begin pick = SEL_DEPD;  pend_clr = 3'b010; end
      else if (pend[0]) begin pick = SEL_EXAMD; pend_clr = 3'b001; end
    end
  end

  // Panel request and continue bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= 3'b000;
      sel       <= SEL_NONE;
      pend_cont <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) |
              (halted ? {loadd_sw, depd_sw, examd_sw} : 3'b000);
      if (state == H0)      sel <= pick;
      else if (state == H3) sel <= SEL_NONE;
      // Consuming the continue (taken or refused by halt_sw) wins over a new
      // pulse so a stale flag never survives into the run.
      if (cont_eval)                pend_cont <= 1'b0;
      else if (halted && cont_sw)   pend_cont <= 1'b1;
    end
  end

  // Opcode capture for the D3 decision (datapath register, no reset)
  always_ff @(posedge clk) begin
    if (state == F3) ir_op <= cur_op;
  end

endmodule
